cp0_exc_handler: RTL and testbench

Coprocessor-0 exception/interrupt sink at the M stage of the 5-stage MIPS pipeline. It consumes the ExcGet/ExcCode chain produced by the per-stage exception checkers, plus six hardware interrupt lines. It arbitrates between interrupts and exceptions and latches EPC, Cause and SR, then drives the flush/redirect request to the handler entry. It also services mfc0/mtc0 register accesses and eret.

---
 rtl/cp0_exc_handler.sv | 167 ++++++++++++++++
 tb/tb_cp0_exc_handler.sv | 236 +++++++++++++++++++++++
 2 files changed

// File: rtl/cp0_exc_handler.sv
// CP0 exception/interrupt sink for the M stage: SR/Cause/EPC/PRId, trap arbitration, eret and mfc0/mtc0.
// Optional Count/Compare timer on HWInt[5] is enabled by defining CP0_TIMER_EN.
module cp0_exc_handler #(
  parameter logic [31:0] PRID         = 32'h0000_4C31,
  parameter logic [31:0] HANDLER_ADDR = 32'h0000_4180
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [31:0] PC,
  input  logic        BD,
  input  logic        ExcGet,
  input  logic [4:0]  ExcCode,
  input  logic [5:0]  HWInt,
  input  logic        We,
  input  logic [4:0]  Addr,
  input  logic [31:0] Din,
  input  logic        EXLClr,
  output logic [31:0] Dout,
  output logic [31:0] EPCOut,
  output logic        Req,
  output logic [31:0] EntryPC
);

  localparam logic [4:0] ADDR_COUNT   = 5'd9;
  localparam logic [4:0] ADDR_COMPARE = 5'd11;
  localparam logic [4:0] ADDR_SR      = 5'd12;
  localparam logic [4:0] ADDR_CAUSE   = 5'd13;
  localparam logic [4:0] ADDR_EPC     = 5'd14;
  localparam logic [4:0] ADDR_PRID    = 5'd15;

  // The FSM state is SR.EXL itself.
  typedef enum logic {
    NORMAL  = 1'b0,
    HANDLER = 1'b1
  } state_t;

  state_t      state, state_next;
  logic [5:0]  sr_im;
  logic        sr_ie;
  logic        cause_bd;
  logic [5:0]  cause_ip;
  logic [4:0]  cause_exc;
  logic [29:0] epc_hi;

  logic        sr_exl;
  logic [5:0]  hw_eff;
  logic        int_pend;
  logic        exc_pend;
  logic        wr;
  logic        wr_sr;
  logic        wr_epc;
  logic [31:0] trap_pc;
  logic [31:0] sr_val;
  logic [31:0] cause_val;
  logic [31:0] epc_val;

  assign sr_exl = (state == HANDLER);

`ifdef CP0_TIMER_EN
  logic [31:0] count;
  logic [31:0] compare;
  logic        timer_ip;

  assign hw_eff = HWInt | {timer_ip, 5'b0};
`else
  assign hw_eff = HWInt;
`endif

  assign int_pend = (|(hw_eff & sr_im)) & sr_ie & ~sr_exl;
  assign exc_pend = ExcGet & ~sr_exl;
  assign Req      = (int_pend | exc_pend) & reset;

  // A trap in the same cycle swallows any mtc0.
  assign wr      = We & ~Req;
  assign wr_sr   = wr & (Addr == ADDR_SR);
  assign wr_epc  = wr & (Addr == ADDR_EPC);
  assign trap_pc = BD ? (PC - 32'd4) : PC;

  // NOTE: every signal written here gets a default first so no latch is inferred.
  always_comb begin
    state_next = state;
    if (Req)
      state_next = HANDLER;
    else if (EXLClr)
      state_next = NORMAL;
    else if (wr_sr)
      state_next = Din[1] ? HANDLER : NORMAL;
  end

  // NOTE: reset is synchronous, so it sits inside the clocked block and outranks every other update.
  always_ff @(posedge clk) begin
    if (!reset)
      state <= NORMAL;
    else
      state <= state_next;
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      sr_im     <= '0;
      sr_ie     <= 1'b0;
      cause_bd  <= 1'b0;
      cause_ip  <= '0;
      cause_exc <= '0;
      epc_hi    <= '0;
    end else begin
      cause_ip <= hw_eff;
      if (Req) begin
        cause_exc <= int_pend ? 5'd0 : ExcCode;
        cause_bd  <= BD;
        epc_hi    <= trap_pc[31:2];
      end else begin
        if (wr_sr) begin
          sr_im <= Din[15:10];
          sr_ie <= Din[0];
        end
        if (wr_epc)
          epc_hi <= Din[31:2];
      end
    end
  end

`ifdef CP0_TIMER_EN
  always_ff @(posedge clk) begin
    if (!reset) begin
      count    <= '0;
      compare  <= '0;
      timer_ip <= 1'b0;
    end else begin
      if (wr && (Addr == ADDR_COUNT))
        count <= Din;
      else
        count <= count + 32'd1;

      if (wr && (Addr == ADDR_COMPARE)) begin
        compare  <= Din;
        timer_ip <= 1'b0;
      end else if (count == compare) begin
        timer_ip <= 1'b1;
      end
    end
  end
`endif

  assign sr_val    = {16'b0, sr_im, 8'b0, sr_exl, sr_ie};
  assign cause_val = {cause_bd, 15'b0, cause_ip, 3'b0, cause_exc, 2'b0};
  assign epc_val   = {epc_hi, 2'b00};

  always_comb begin
    Dout = '0;
    unique case (Addr)
      ADDR_SR:    Dout = sr_val;
      ADDR_CAUSE: Dout = cause_val;
      ADDR_EPC:   Dout = epc_val;
      ADDR_PRID:  Dout = PRID;
`ifdef CP0_TIMER_EN
      ADDR_COUNT:   Dout = count;
      ADDR_COMPARE: Dout = compare;
`endif
      default:    Dout = '0;
    endcase
  end

  assign EPCOut  = epc_val;
  assign EntryPC = HANDLER_ADDR;

endmodule

// File: tb/tb_cp0_exc_handler.sv
// Directed bench for cp0_exc_handler: expected values go into a scoreboard queue and are popped at each DUT sample.
// Define CP0_TIMER_EN to add the Count/Compare checks.
module tb_cp0_exc_handler;

  localparam logic [31:0] PRID         = 32'h0000_4C31;
  localparam logic [31:0] HANDLER_ADDR = 32'h0000_4180;

  logic        clk;
  logic        reset;
  logic [31:0] PC;
  logic        BD;
  logic        ExcGet;
  logic [4:0]  ExcCode;
  logic [5:0]  HWInt;
  logic        We;
  logic [4:0]  Addr;
  logic [31:0] Din;
  logic        EXLClr;
  logic [31:0] Dout;
  logic [31:0] EPCOut;
  logic        Req;
  logic [31:0] EntryPC;

  cp0_exc_handler #(.PRID(PRID), .HANDLER_ADDR(HANDLER_ADDR)) dut (
    .clk(clk), .reset(reset), .PC(PC), .BD(BD), .ExcGet(ExcGet), .ExcCode(ExcCode),
    .HWInt(HWInt), .We(We), .Addr(Addr), .Din(Din), .EXLClr(EXLClr),
    .Dout(Dout), .EPCOut(EPCOut), .Req(Req), .EntryPC(EntryPC)
  );

  initial clk = 1'b0;
  always #50 clk = ~clk;

  typedef struct {
    string       tag;
    logic [31:0] val;
  } exp_t;

  exp_t sb[$];
  int   n_assert = 0;
  int   n_fail   = 0;

  task automatic expect_val(input string tag, input logic [31:0] v);
    exp_t e;
    e.tag = tag;
    e.val = v;
    sb.push_back(e);
  endtask

  task automatic check(input logic [31:0] obs);
    exp_t e;
    n_assert++;
    if (sb.size() == 0) begin
      n_fail++;
      $error("FAIL scoreboard_empty observed=%h expected=<entry>", obs);
    end else begin
      e = sb.pop_front();
      assert (obs === e.val)
      else begin
        n_fail++;
        $error("FAIL %s observed=%h expected=%h", e.tag, obs, e.val);
      end
    end
  endtask

  // Inputs change 1 unit after the rising edge; samples are taken well before the next one.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic read_reg(input logic [4:0] a, input string tag, input logic [31:0] v);
    We   = 1'b0;
    Addr = a;
    expect_val(tag, v);
    #1;
    check(Dout);
  endtask

  task automatic check_req(input string tag, input logic v);
    expect_val(tag, {31'b0, v});
    #1;
    check({31'b0, Req});
  endtask

  task automatic mtc0(input logic [4:0] a, input logic [31:0] d);
    We   = 1'b1;
    Addr = a;
    Din  = d;
    tick();
    We   = 1'b0;
  endtask

  initial begin
    reset = 1'b0; PC = '0; BD = 1'b0; ExcGet = 1'b1; ExcCode = '0;
    HWInt = 6'h3F; We = 1'b0; Addr = '0; Din = '0; EXLClr = 1'b0;

    // Reset holds Req low even with every trap source active.
    check_req("req_in_reset_t0", 1'b0);
    tick();
    check_req("req_in_reset_c1", 1'b0);
    tick();
    check_req("req_in_reset_c2", 1'b0);
    reset = 1'b1; ExcGet = 1'b0; HWInt = 6'h00;
    tick();
    read_reg(5'd12, "sr_after_reset", 32'h0);
    read_reg(5'd13, "cause_after_reset", 32'h0);
    read_reg(5'd14, "epc_after_reset", 32'h0);
    expect_val("entry_pc", HANDLER_ADDR);
    check(EntryPC);

    // mtc0 SR; a read in the write cycle still sees the old value.
    We = 1'b1; Addr = 5'd12; Din = 32'h0000_FC01;
    expect_val("sr_read_during_write", 32'h0);
    #1;
    check(Dout);
    tick();
    We = 1'b0;
    read_reg(5'd12, "sr_written", 32'h0000_FC01);
    mtc0(5'd13, 32'hFFFF_FFFF);
    read_reg(5'd13, "cause_write_dropped", 32'h0);

    // Overflow exception outside a delay slot.
    ExcGet = 1'b1; ExcCode = 5'd12; PC = 32'h0000_3010; BD = 1'b0;
    check_req("req_ov", 1'b1);
    tick();
    ExcGet = 1'b0;
    check_req("req_one_cycle", 1'b0);
    read_reg(5'd13, "cause_ov", 32'h0000_0030);
    read_reg(5'd14, "epc_ov", 32'h0000_3010);
    read_reg(5'd12, "sr_ov", 32'h0000_FC03);
    expect_val("epcout_ov", 32'h0000_3010);
    check(EPCOut);

    // eret, then an interrupt racing an exception in a delay slot.
    EXLClr = 1'b1;
    tick();
    EXLClr = 1'b0;
    read_reg(5'd12, "sr_after_eret", 32'h0000_FC01);
    mtc0(5'd12, 32'h0000_0401);
    read_reg(5'd12, "sr_im10", 32'h0000_0401);
    HWInt = 6'h01; ExcGet = 1'b1; ExcCode = 5'd4; PC = 32'h0000_3020; BD = 1'b1;
    check_req("req_int", 1'b1);
    tick();
    ExcGet = 1'b0; BD = 1'b0;
    check_req("req_masked_by_exl", 1'b0);
    read_reg(5'd13, "cause_int", 32'h8000_0400);
    read_reg(5'd14, "epc_int_bd", 32'h0000_301C);
    read_reg(5'd12, "sr_int", 32'h0000_0403);

    // No nesting while in HANDLER.
    ExcGet = 1'b1; ExcCode = 5'd10;
    check_req("req_handler_ignored", 1'b0);
    tick();
    ExcGet = 1'b0;
    read_reg(5'd13, "cause_unchanged_in_handler", 32'h8000_0400);

    // eret together with an SR write setting EXL: eret wins the EXL bit.
    EXLClr = 1'b1;
    mtc0(5'd12, 32'h0000_0403);
    EXLClr = 1'b0;
    read_reg(5'd12, "sr_eret_vs_write", 32'h0000_0401);
    check_req("req_pending_int_after_eret", 1'b1);

    // Trap and mtc0 EPC in the same cycle: the trap wins.
    PC = 32'h0000_4000; BD = 1'b0;
    mtc0(5'd14, 32'h1234_5678);
    HWInt = 6'h00;
    read_reg(5'd14, "epc_trap_beats_write", 32'h0000_4000);
    read_reg(5'd13, "cause_int_nobd", 32'h0000_0400);
    read_reg(5'd3, "unmapped_reads_zero", 32'h0);
    read_reg(5'd15, "prid", PRID);
`ifndef CP0_TIMER_EN
    read_reg(5'd9, "count_absent", 32'h0);
    read_reg(5'd11, "compare_absent", 32'h0);
`endif

    // eret, then eret again in NORMAL is harmless.
    EXLClr = 1'b1;
    tick();
    tick();
    EXLClr = 1'b0;
    read_reg(5'd12, "sr_eret_in_normal", 32'h0000_0401);

    // PC-4 wraps when PC=0 in a delay slot.
    ExcGet = 1'b1; ExcCode = 5'd8; PC = 32'h0; BD = 1'b1;
    check_req("req_wrap", 1'b1);
    tick();
    ExcGet = 1'b0; BD = 1'b0;
    read_reg(5'd14, "epc_wrap", 32'hFFFF_FFFC);
    expect_val("epcout_wrap", 32'hFFFF_FFFC);
    check(EPCOut);
    read_reg(5'd13, "cause_wrap", 32'h8000_0020);
    mtc0(5'd14, 32'h0000_5007);
    read_reg(5'd14, "epc_write_aligned", 32'h0000_5004);

    // Reset overrides a concurrent write and clears everything.
    reset = 1'b0; We = 1'b1; Addr = 5'd12; Din = 32'h0000_FC01; ExcGet = 1'b1;
    check_req("req_low_in_reset", 1'b0);
    tick();
    reset = 1'b1; We = 1'b0; ExcGet = 1'b0;
    read_reg(5'd12, "sr_reset_wins", 32'h0);
    read_reg(5'd14, "epc_reset_wins", 32'h0);
    read_reg(5'd13, "cause_reset_wins", 32'h0);

`ifdef CP0_TIMER_EN
    begin
      bit got_req;
      got_req = 1'b0;
      mtc0(5'd11, 32'd5);
      mtc0(5'd9, 32'd0);
      mtc0(5'd12, 32'h0000_8001);
      for (int i = 0; i < 20; i++) begin
        #1;
        if (Req) begin
          got_req = 1'b1;
          break;
        end
        if (i < 2)
          read_reg(5'd9, "count_running", 32'd1 + 32'(i));
        tick();
      end
      expect_val("timer_req_within_bound", 32'd1);
      check({31'b0, got_req});
      tick();
      read_reg(5'd13, "cause_timer_ip", 32'h0000_8000);
      mtc0(5'd11, 32'd1000);
      tick();
      read_reg(5'd13, "cause_ip_cleared", 32'h0);
    end
`endif

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
